uart_imem_loader: RTL and testbench
===================================

UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

Interface
REQ-001 The block SHALL have parameter MEM_SIZE_BYTES, default 2**17: instruction memory size in bytes, used for the address range check.
REQ-002 The block SHALL have parameter READ_LATENCY, default 1: cycles from o_instr_mem_en to valid i_instr_mem_rddata.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum idle cycles between bytes of one frame.
REQ-004 The block SHALL have these ports, one per line as name, direction, width, meaning:
i_clk  input  1  single clock for all logic.
i_rst_n  input  1  reset, asynchronous and active-low.
i_rx_data  input  8  received byte from the UART RX FIFO.
i_rx_valid  input  1  i_rx_data is valid.
o_rx_ready  output  1  loader accepts a byte.
o_tx_data  output  8  response byte to the UART TX FIFO.
o_tx_valid  output  1  o_tx_data is valid.
i_tx_ready  input  1  TX side accepts the byte.
o_instr_mem_en  output  1  memory port enable.
o_instr_mem_we  output  4  byte write enables.
o_instr_mem_addr  output  32  byte address.
o_instr_mem_wrdata  output  32  write data.
i_instr_mem_rddata  input  32  read data.
o_cpu_rst  output  1  active-high hold-in-reset to the CPU.
o_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-005 A byte SHALL be transferred only in a cycle with valid and ready both high, on both the RX and TX streams.
REQ-006 A frame SHALL consist of sync byte 0xA5, a command byte, 4 address bytes (little-endian) and, for WRITE only, 4 data bytes (little-endian); commands are 0x01 WRITE, 0x02 READ, 0x03 RUN, 0x04 HALT, and RUN/HALT carry no address bytes.
REQ-007 The FSM states SHALL be IDLE, CMD, ADDR, DATA, MEM, RD_WAIT and RESP.
REQ-008 o_rx_ready SHALL be 1 in IDLE, CMD, ADDR and DATA, and 0 in all other states.
REQ-009 In IDLE, any byte other than 0xA5 SHALL be discarded with no response.
REQ-010 An unknown command byte SHALL produce the single response byte 0xEE (NAK), followed by a return to IDLE.
REQ-011 Address bits [1:0] SHALL be ignored (forced to 0).
REQ-012 An address >= MEM_SIZE_BYTES SHALL produce a NAK with no memory access.
REQ-013 WRITE: one cycle after the last data byte is accepted, the block SHALL assert o_instr_mem_en=1 and o_instr_mem_we=4'hF for exactly one cycle, then respond 0x5A (ACK).
REQ-014 READ: the block SHALL assert o_instr_mem_en=1 with we=0 for one cycle, capture i_instr_mem_rddata READ_LATENCY cycles later, then emit 4 bytes LSB first.
REQ-015 RUN SHALL respond ACK, and o_cpu_rst SHALL fall in the cycle after that ACK transfers; HALT SHALL set o_cpu_rst=1 in the cycle after its command byte is accepted, then ACK.
REQ-016 While i_tx_ready is low, o_tx_valid and o_tx_data SHALL hold stable; no byte SHALL be dropped or duplicated.
REQ-017 The timeout counter SHALL clear on every accepted byte and count only in CMD, ADDR and DATA; when it reaches TIMEOUT_CYCLES-1, the FSM SHALL return to IDLE silently.
REQ-018 o_instr_mem_en SHALL be 0 in every cycle not specified above; o_instr_mem_addr and o_instr_mem_wrdata are don't-care while en=0.

Reset
REQ-019 Asserting i_rst_n low SHALL immediately drive: FSM=IDLE, o_rx_ready=0, o_tx_valid=0, o_instr_mem_en=0, o_instr_mem_we=0, o_cpu_rst=1, o_busy=0, and all counters and byte buffers to 0.
REQ-020 Reset mid-frame or mid-response SHALL abandon the frame; after release, the block SHALL wait for a fresh sync byte.
REQ-021 o_rx_ready SHALL go high in the first cycle after reset release.

Structure
REQ-022 Package uart_imem_loader_pkg SHALL hold the sync, ACK and NAK constants, the command code enum and the FSM state enum.
REQ-023 The 4-byte little-endian response serializer SHALL be a sub-module named loader_tx_serializer, with a valid/ready handshake on both sides.

Verification
REQ-024 Stimulus A5 01 00 01 00 00 EF BE AD DE -> one write cycle at addr 0x100 with data 0xDEADBEEF and we=F, then TX 5A.
REQ-025 Same WRITE, then A5 02 00 01 00 00 with memory model returning 0xDEADBEEF -> TX EF BE AD DE; with i_tx_ready toggling every other cycle, the same 4 bytes in order.
REQ-026 Stimulus A5 07 -> TX EE; then A5 01 00 00 02 00 + data (0x20000 >= 128KB) -> TX EE and no o_instr_mem_en pulse.
REQ-027 Stimulus 13 A5 03 -> 13 ignored, TX 5A, o_cpu_rst falls the cycle after the ACK; then A5 04 -> o_cpu_rst=1.
REQ-028 With TIMEOUT_CYCLES=16: A5 01 00, then 16 idle cycles -> return to IDLE with no TX; a following full frame is handled normally.
REQ-029 i_rst_n pulsed low during the DATA state -> all outputs at reset values within the same cycle, o_cpu_rst=1, and no memory write occurs.

Source files
------------

// File: rtl/uart_imem_loader_pkg.sv
// rtl/uart_imem_loader_pkg.sv - frame constants, command codes and FSM states for the UART loader
package uart_imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h5A;
  localparam logic [7:0] NAK_BYTE  = 8'hEE;

  typedef enum logic [7:0] {
    CMD_WRITE = 8'h01,
    CMD_READ  = 8'h02,
    CMD_RUN   = 8'h03,
    CMD_HALT  = 8'h04
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_MEM,
    ST_RD_WAIT,
    ST_RESP
  } state_e;

  // States in which the loader is willing to take a byte from the RX FIFO.
  function automatic logic rx_state(input state_e s);
    return (s == ST_IDLE) || (s == ST_CMD) || (s == ST_ADDR) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/loader_tx_serializer.sv
// rtl/loader_tx_serializer.sv - emits 1..4 bytes of a word LSB first over a valid/ready byte stream
module loader_tx_serializer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_word,
  input  logic [2:0]  i_len,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready
);

  logic [31:0] word_q;
  logic [2:0]  cnt_q;

  assign o_ready    = (cnt_q == 3'd0);
  assign o_tx_valid = (cnt_q != 3'd0);
  assign o_tx_data  = word_q[7:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (i_valid && o_ready) begin
      word_q <= i_word;
      cnt_q  <= i_len;
    end else if (o_tx_valid && i_tx_ready) begin
      word_q <= {8'h00, word_q[31:8]};
      cnt_q  <= cnt_q - 3'd1;
    end
  end

endmodule

// File: rtl/uart_imem_loader.sv
// rtl/uart_imem_loader.sv - UART framed loader: writes/reads instruction memory and controls CPU reset
module uart_imem_loader #(
  parameter int MEM_SIZE_BYTES = 2**17,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_instr_mem_en,
  output logic [3:0]  o_instr_mem_we,
  output logic [31:0] o_instr_mem_addr,
  output logic [31:0] o_instr_mem_wrdata,
  input  logic [31:0] i_instr_mem_rddata,
  output logic        o_cpu_rst,
  output logic        o_busy
);
  import uart_imem_loader_pkg::*;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_SIZE_BYTES);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] LAT_LAST  = 32'(READ_LATENCY - 1);

  state_e      state_q;
  cmd_e        cmd_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] tmo_q;
  logic [31:0] lat_q;
  logic        en_q;
  logic [3:0]  we_q;
  logic        cpu_rst_q;
  logic        run_pend_q;
  logic        rx_en_q;
  logic        ser_valid_q;
  logic [31:0] ser_word_q;
  logic [2:0]  ser_len_q;
  logic        ser_ready;
  logic        rx_fire;
  logic [31:0] addr_full;

  function automatic logic out_of_range(input logic [31:0] a);
    return {1'b0, a} >= MEM_LIMIT;
  endfunction

  // rx_en_q keeps ready low throughout reset and lets it rise on the first clock after release.
  assign o_rx_ready         = rx_en_q & rx_state(state_q);
  assign o_busy             = (state_q != ST_IDLE);
  assign o_instr_mem_en     = en_q;
  assign o_instr_mem_we     = we_q;
  assign o_instr_mem_addr   = addr_q;
  assign o_instr_mem_wrdata = data_q;
  assign o_cpu_rst          = cpu_rst_q;
  assign rx_fire            = o_rx_ready & i_rx_valid;
  // Address as it will stand once the current (last) address byte lands, low bits forced to 0.
  assign addr_full          = {i_rx_data, addr_q[31:10], 2'b00};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_WRITE;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tmo_q       <= '0;
      lat_q       <= '0;
      en_q        <= 1'b0;
      we_q        <= '0;
      cpu_rst_q   <= 1'b1;
      run_pend_q  <= 1'b0;
      rx_en_q     <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_word_q  <= '0;
      ser_len_q   <= '0;
    end else begin
      rx_en_q <= 1'b1;

      if (run_pend_q && o_tx_valid && i_tx_ready) begin
        cpu_rst_q  <= 1'b0;
        run_pend_q <= 1'b0;
      end

      if (state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_DATA) begin
        if (rx_fire) begin
          tmo_q <= '0;
        end else if (tmo_q == TMO_LAST) begin
          tmo_q   <= '0;
          state_q <= ST_IDLE;
        end else begin
          tmo_q <= tmo_q + 32'd1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (rx_fire && i_rx_data == SYNC_BYTE) begin
            state_q <= ST_CMD;
            tmo_q   <= '0;
          end
        end
        ST_CMD: begin
          if (rx_fire) begin
            byte_cnt_q <= '0;
            if (i_rx_data == CMD_WRITE || i_rx_data == CMD_READ) begin
              cmd_q   <= cmd_e'(i_rx_data);
              state_q <= ST_ADDR;
            end else begin
              state_q     <= ST_RESP;
              ser_valid_q <= 1'b1;
              ser_len_q   <= 3'd1;
              if (i_rx_data == CMD_RUN) begin
                run_pend_q <= 1'b1;
                ser_word_q <= {24'h0, ACK_BYTE};
              end else if (i_rx_data == CMD_HALT) begin
                cpu_rst_q  <= 1'b1;
                ser_word_q <= {24'h0, ACK_BYTE};
              end else begin
                ser_word_q <= {24'h0, NAK_BYTE};
              end
            end
          end
        end
        ST_ADDR: begin
          if (rx_fire) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              addr_q <= addr_full;
              if (cmd_q == CMD_WRITE) begin
                state_q <= ST_DATA;
              end else if (out_of_range(addr_full)) begin
                state_q     <= ST_RESP;
                ser_valid_q <= 1'b1;
                ser_word_q  <= {24'h0, NAK_BYTE};
                ser_len_q   <= 3'd1;
              end else begin
                en_q    <= 1'b1;
                we_q    <= 4'h0;
                state_q <= ST_MEM;
              end
            end else begin
              addr_q <= {i_rx_data, addr_q[31:8]};
            end
          end
        end
        ST_DATA: begin
          if (rx_fire) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            data_q     <= {i_rx_data, data_q[31:8]};
            if (byte_cnt_q == 2'd3) begin
              if (out_of_range(addr_q)) begin
                state_q     <= ST_RESP;
                ser_valid_q <= 1'b1;
                ser_word_q  <= {24'h0, NAK_BYTE};
                ser_len_q   <= 3'd1;
              end else begin
                en_q    <= 1'b1;
                we_q    <= 4'hF;
                state_q <= ST_MEM;
              end
            end
          end
        end
        ST_MEM: begin
          en_q  <= 1'b0;
          we_q  <= 4'h0;
          lat_q <= '0;
          if (cmd_q == CMD_WRITE) begin
            state_q     <= ST_RESP;
            ser_valid_q <= 1'b1;
            ser_word_q  <= {24'h0, ACK_BYTE};
            ser_len_q   <= 3'd1;
          end else begin
            state_q <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (lat_q == LAT_LAST) begin
            state_q     <= ST_RESP;
            ser_valid_q <= 1'b1;
            ser_word_q  <= i_instr_mem_rddata;
            ser_len_q   <= 3'd4;
          end else begin
            lat_q <= lat_q + 32'd1;
          end
        end
        ST_RESP: begin
          // Hand the word over once, then wait for the serializer to drain.
          if (ser_valid_q) begin
            if (ser_ready) ser_valid_q <= 1'b0;
          end else if (ser_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  loader_tx_serializer u_tx_ser (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_word     (ser_word_q),
    .i_len      (ser_len_q),
    .i_valid    (ser_valid_q),
    .o_ready    (ser_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready)
  );

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb/tb_uart_imem_loader.sv - directed bench for uart_imem_loader with memory model and TX capture
module tb_uart_imem_loader;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        i_tx_ready = 1'b1;
  logic [31:0] i_instr_mem_rddata = 32'h0;
  logic        o_rx_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        o_instr_mem_en;
  logic [3:0]  o_instr_mem_we;
  logic [31:0] o_instr_mem_addr;
  logic [31:0] o_instr_mem_wrdata;
  logic        o_cpu_rst;
  logic        o_busy;

  uart_imem_loader #(
    .MEM_SIZE_BYTES (2**17),
    .READ_LATENCY   (1),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_rx_data          (i_rx_data),
    .i_rx_valid         (i_rx_valid),
    .o_rx_ready         (o_rx_ready),
    .o_tx_data          (o_tx_data),
    .o_tx_valid         (o_tx_valid),
    .i_tx_ready         (i_tx_ready),
    .o_instr_mem_en     (o_instr_mem_en),
    .o_instr_mem_we     (o_instr_mem_we),
    .o_instr_mem_addr   (o_instr_mem_addr),
    .o_instr_mem_wrdata (o_instr_mem_wrdata),
    .i_instr_mem_rddata (i_instr_mem_rddata),
    .o_cpu_rst          (o_cpu_rst),
    .o_busy             (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          en_cnt = 0;
  int          en_cyc = -1;
  int          last_acc = -1;
  int          last_tx_cyc = -1;
  int          rst_fall_cyc = -1;
  logic        cpu_rst_prev = 1'b1;
  logic        tx_toggle = 1'b0;
  logic [3:0]  en_we = 4'h0;
  logic [31:0] en_addr = 32'h0;
  logic [31:0] en_wd = 32'h0;
  logic [31:0] mem [0:1023];
  logic [7:0]  tx_q [$];
  int          e0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Memory model: one-cycle registered read.
  always @(posedge i_clk) if (o_instr_mem_en) i_instr_mem_rddata <= mem[o_instr_mem_addr[11:2]];

  always @(negedge i_clk) begin
    if (o_instr_mem_en) begin
      en_cnt++;
      en_cyc  = cyc;
      en_we   = o_instr_mem_we;
      en_addr = o_instr_mem_addr;
      en_wd   = o_instr_mem_wrdata;
      if (o_instr_mem_we == 4'hF) mem[o_instr_mem_addr[11:2]] = o_instr_mem_wrdata;
    end
    if (o_tx_valid && i_tx_ready) begin
      tx_q.push_back(o_tx_data);
      last_tx_cyc = cyc;
    end
    if (cpu_rst_prev && !o_cpu_rst) rst_fall_cyc = cyc;
    cpu_rst_prev = o_cpu_rst;
  end

  initial forever begin
    @(posedge i_clk);
    #2;
    i_tx_ready = tx_toggle ? ~i_tx_ready : 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    while (!o_rx_ready && k < 100) begin
      @(negedge i_clk);
      k++;
    end
    if (o_rx_ready) @(posedge i_clk);
    else chk("rx_ready_wait", 32'(o_rx_ready), 32'h1);
    @(negedge i_clk);
    last_acc   = cyc;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (o_busy && k < 300) begin
      @(negedge i_clk);
      k++;
    end
    chk(tag, 32'(o_busy), 32'h0);
  endtask

  task automatic expect_tx(input string tag, input int n, input logic [31:0] w);
    chk({tag, "_len"}, 32'(tx_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < tx_q.size()) chk({tag, "_byte"}, 32'(tx_q[i]), 32'(w[8*i +: 8]));
    end
    tx_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_rx_ready", 32'(o_rx_ready), 32'h0);
    chk("rst_tx_valid", 32'(o_tx_valid), 32'h0);
    chk("rst_mem_en", 32'(o_instr_mem_en), 32'h0);
    chk("rst_mem_we", 32'(o_instr_mem_we), 32'h0);
    chk("rst_cpu_rst", 32'(o_cpu_rst), 32'h1);
    chk("rst_busy", 32'(o_busy), 32'h0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("ready_after_rst", 32'(o_rx_ready), 32'h1);

    // WRITE 0xDEADBEEF to 0x100
    e0 = en_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_word(32'h0000_0100); send_word(32'hDEAD_BEEF);
    wait_idle("wr_idle");
    chk("wr_en_pulses", 32'(en_cnt - e0), 32'h1);
    chk("wr_en_timing", 32'(en_cyc), 32'(last_acc));
    chk("wr_addr", en_addr, 32'h0000_0100);
    chk("wr_data", en_wd, 32'hDEAD_BEEF);
    chk("wr_we", 32'(en_we), 32'hF);
    expect_tx("wr_ack", 1, 32'h5A);

    // READ back, TX always ready, then with TX ready toggling
    for (int pass = 0; pass < 2; pass++) begin
      tx_toggle = (pass == 1);
      e0 = en_cnt;
      send_byte(8'hA5); send_byte(8'h02); send_word(32'h0000_0100);
      wait_idle("rd_idle");
      chk("rd_en_pulses", 32'(en_cnt - e0), 32'h1);
      chk("rd_we", 32'(en_we), 32'h0);
      expect_tx(pass == 0 ? "rd" : "rd_stall", 4, 32'hDEAD_BEEF);
    end
    tx_toggle = 1'b0;

    // unknown command
    send_byte(8'hA5); send_byte(8'h07);
    wait_idle("badcmd_idle");
    expect_tx("badcmd_nak", 1, 32'hEE);

    // address at the memory limit
    e0 = en_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_word(32'h0002_0000); send_word(32'h1122_3344);
    wait_idle("range_idle");
    chk("range_no_en", 32'(en_cnt - e0), 32'h0);
    expect_tx("range_nak", 1, 32'hEE);

    // junk byte then RUN
    send_byte(8'h13);
    chk("junk_not_busy", 32'(o_busy), 32'h0);
    send_byte(8'hA5); send_byte(8'h03);
    wait_idle("run_idle");
    chk("run_cpu_rst", 32'(o_cpu_rst), 32'h0);
    chk("run_fall_cycle", 32'(rst_fall_cyc), 32'(last_tx_cyc + 1));
    expect_tx("run_ack", 1, 32'h5A);

    // HALT
    send_byte(8'hA5); send_byte(8'h04);
    chk("halt_cpu_rst", 32'(o_cpu_rst), 32'h1);
    wait_idle("halt_idle");
    expect_tx("halt_ack", 1, 32'h5A);

    // inter-byte timeout after A5 01 00
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    repeat (15) @(negedge i_clk);
    chk("tmo_busy_15", 32'(o_busy), 32'h1);
    @(negedge i_clk);
    chk("tmo_busy_16", 32'(o_busy), 32'h0);
    chk("tmo_no_tx", 32'(tx_q.size()), 32'h0);
    send_byte(8'hA5); send_byte(8'h01); send_word(32'h0000_0040); send_word(32'h1234_5678);
    wait_idle("tmo_wr_idle");
    chk("tmo_wr_addr", en_addr, 32'h0000_0040);
    chk("tmo_wr_data", en_wd, 32'h1234_5678);
    expect_tx("tmo_wr_ack", 1, 32'h5A);

    // release CPU, then reset in the middle of DATA
    send_byte(8'hA5); send_byte(8'h03);
    wait_idle("run2_idle");
    tx_q.delete();
    e0 = en_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_word(32'h0000_0080); send_byte(8'h11); send_byte(8'h22);
    chk("mid_busy", 32'(o_busy), 32'h1);
    i_rst_n = 1'b0;
    #1;
    chk("mrst_rx_ready", 32'(o_rx_ready), 32'h0);
    chk("mrst_busy", 32'(o_busy), 32'h0);
    chk("mrst_cpu_rst", 32'(o_cpu_rst), 32'h1);
    chk("mrst_mem_en", 32'(o_instr_mem_en), 32'h0);
    chk("mrst_tx_valid", 32'(o_tx_valid), 32'h0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    send_byte(8'h33); send_byte(8'h44);
    repeat (3) @(negedge i_clk);
    chk("mrst_no_write", 32'(en_cnt - e0), 32'h0);
    chk("mrst_idle", 32'(o_busy), 32'h0);
    chk("mrst_no_tx", 32'(tx_q.size()), 32'h0);
    send_byte(8'hA5); send_byte(8'h02); send_word(32'h0000_0100);
    wait_idle("mrst_rd_idle");
    expect_tx("mrst_rd", 4, 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
